mem_access_unit: RTL and testbench

- Memory-stage sequencer that sits directly upstream of the data memory.
- Takes load/store requests from the EX/MEM pipeline register and drives the memory's read/write strobes, addresses and write data.
- Splits 32-bit (double-word: PUSH/POP PC, CALL/RET) accesses into two 16-bit memory accesses, stalling the pipeline for the extra cycle.
- Returns assembled read data and an out-of-range flag to the MEM/WB stage.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_addr_check.sv | 21 ++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and constants for the memory-stage access sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 16;

    // Access size as carried by req_double
    localparam logic SZ_WORD  = 1'b0;
    localparam logic SZ_DWORD = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } mau_state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_addr_check.sv
`default_nettype none
// ============================================================================
// Module   : mem_addr_check
// Brief    : Combinational word-address range check (addr < DEPTH).
// Revision : 1.0 - initial release
// ============================================================================
module mem_addr_check #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    // One extra bit so a DEPTH equal to 2^ADDR_W still compares correctly
    localparam logic [ADDR_W:0] c_limit = (ADDR_W+1)'(DEPTH);

    assign in_range = ({1'b0, addr} < c_limit);

endmodule : mem_addr_check
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Memory-stage sequencer; splits 32-bit accesses into two 16-bit
//            memory cycles and returns assembled load data to MEM/WB.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic                  req_double,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [2*DATA_W-1:0]   resp_rdata,
    output logic                  resp_err
);

    mau_state_t          r_state;
    mau_state_t          w_state_next;

    logic [ADDR_W-1:0]   r_addr2;
    logic                r_write;
    logic [DATA_W-1:0]   r_lo_wdata;
    logic [DATA_W-1:0]   r_hi_rdata;
    logic                r_err;

    logic                w_ok_live;
    logic                w_ok_lat;
    logic                w_accept;
    logic                w_is_dword;
    logic [DATA_W-1:0]   w_rword_live;
    logic [DATA_W-1:0]   w_rword_lat;

    mem_addr_check #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_chk_live (
        .addr     (req_addr),
        .in_range (w_ok_live)
    );

    mem_addr_check #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_chk_lat (
        .addr     (r_addr2),
        .in_range (w_ok_lat)
    );

    assign w_is_dword = (req_double == SZ_DWORD);

    // Out-of-range words read back as zero regardless of what the bus returns
    assign w_rword_live = w_ok_live ? mem_rdata : '0;
    assign w_rword_lat  = w_ok_lat  ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        stall        = 1'b0;
        if (rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        w_accept  = 1'b1;
                        mem_addr  = req_addr;
                        mem_rd    = !req_write && w_ok_live;
                        mem_wr    = req_write && w_ok_live;
                        mem_wdata = w_is_dword ? req_wdata[2*DATA_W-1:DATA_W]
                                               : req_wdata[DATA_W-1:0];
                        if (w_is_dword) begin
                            stall        = 1'b1;
                            w_state_next = ST_SECOND;
                        end
                    end
                end
                ST_SECOND: begin
                    mem_addr     = r_addr2;
                    mem_wdata    = r_lo_wdata;
                    mem_rd       = !r_write && w_ok_lat;
                    mem_wr       = r_write && w_ok_lat;
                    w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr2    <= '0;
            r_write    <= 1'b0;
            r_lo_wdata <= '0;
            r_hi_rdata <= '0;
            r_err      <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            if (w_accept) begin
                if (w_is_dword) begin
                    r_addr2    <= req_addr + ADDR_W'(1);
                    r_write    <= req_write;
                    r_lo_wdata <= req_wdata[DATA_W-1:0];
                    r_hi_rdata <= w_rword_live;
                    r_err      <= !w_ok_live;
                end else begin
                    resp_err <= !w_ok_live;
                    if (!req_write) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= {{DATA_W{1'b0}}, w_rword_live};
                    end
                end
            end else if (r_state == ST_SECOND) begin
                resp_err <= r_err || !w_ok_lat;
                if (!r_write) begin
                    resp_valid <= 1'b1;
                    resp_rdata <= {r_hi_rdata, w_rword_lat};
                end
            end
        end
    end

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Self-checking bench for mem_access_unit with a 32-word memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int AW    = 32;
    localparam int DW    = 16;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_write, req_double;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem     [0:DEPTH-1] = '{default: 16'h0};
    logic [15:0] ref_mem [0:DEPTH-1] = '{default: 16'h0};

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_double (req_double),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    // Memory device; out-of-range reads return garbage the DUT must discard
    always @(posedge clk) begin
        if (mem_wr && mem_addr < DEPTH) mem[mem_addr[4:0]] <= mem_wdata;
    end
    assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[4:0]] : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request from the pipeline's point of view; starts and ends at a negedge
    task automatic issue(input logic w, input logic d, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] a1;
        logic        ok0, ok1;
        logic [15:0] r0, r1;
        a1  = a + 32'd1;
        ok0 = (a < DEPTH);
        ok1 = (a1 < DEPTH);
        r0  = ok0 ? ref_mem[a[4:0]] : 16'h0;
        r1  = ok1 ? ref_mem[a1[4:0]] : 16'h0;
        req_valid = 1'b1; req_write = w; req_double = d; req_addr = a; req_wdata = wd;
        #1;
        chk("stall_first", stall, d);
        chk("rd_first", mem_rd, !w && ok0);
        chk("wr_first", mem_wr, w && ok0);
        chk("addr_first", mem_addr, a);
        chk("wdata_first", mem_wdata, d ? wd[31:16] : wd[15:0]);
        @(posedge clk); #1;
        if (!d) begin
            if (w && ok0) ref_mem[a[4:0]] = wd[15:0];
            chk("valid_single", resp_valid, !w);
            if (!w) chk("rdata_single", resp_rdata, {16'h0, r0});
            chk("err_single", resp_err, !ok0);
        end else begin
            if (w && ok0) ref_mem[a[4:0]] = wd[31:16];
            chk("valid_mid", resp_valid, 1'b0);
            @(negedge clk);
            // Upstream request during the second word must be ignored
            req_valid = 1'(($urandom)); req_write = 1'($urandom); req_double = 1'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
            #1;
            chk("stall_second", stall, 1'b0);
            chk("rd_second", mem_rd, !w && ok1);
            chk("wr_second", mem_wr, w && ok1);
            chk("addr_second", mem_addr, a1);
            chk("wdata_second", mem_wdata, wd[15:0]);
            @(posedge clk); #1;
            if (w && ok1) ref_mem[a1[4:0]] = wd[15:0];
            chk("valid_double", resp_valid, !w);
            if (!w) chk("rdata_double", resp_rdata, {r0, r1});
            chk("err_double", resp_err, !(ok0 && ok1));
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0; req_write = 1'($urandom); req_double = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        #1;
        chk("idle_strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
        chk("idle_addr", mem_addr, 32'h0);
        chk("idle_wdata", mem_wdata, 32'h0);
        chk("idle_stall", stall, 1'b0);
        @(posedge clk); #1;
        chk("idle_valid", resp_valid, 1'b0);
        chk("idle_err", resp_err, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        int mism;
        rst = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_double = 1'b1;
        req_addr = 32'd3; req_wdata = 32'hCAFEF00D;
        #2;
        chk("rst_stall", stall, 1'b0);
        chk("rst_strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
        chk("rst_valid", resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", resp_err, 1'b0);
        @(negedge clk); @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;

        // Single store then load
        issue(1'b1, 1'b0, 32'd5, 32'h000000AB);
        issue(1'b0, 1'b0, 32'd5, 32'h0);
        chk("single_load_value", resp_rdata, 32'h000000AB);

        // Double store/load
        issue(1'b1, 1'b1, 32'd10, 32'h12345678);
        chk("mem10", {16'h0, mem[10]}, 32'h1234);
        chk("mem11", {16'h0, mem[11]}, 32'h5678);
        issue(1'b0, 1'b1, 32'd10, 32'h0);

        // Back-to-back single loads
        issue(1'b0, 1'b0, 32'd1, 32'h0);
        issue(1'b0, 1'b0, 32'd2, 32'h0);
        issue(1'b0, 1'b0, 32'd3, 32'h0);

        // Second word past the end of memory
        issue(1'b1, 1'b0, 32'd31, 32'h0000BEEF);
        issue(1'b0, 1'b1, 32'd31, 32'h0);
        chk("oor_rdata", resp_rdata, 32'hBEEF0000);

        // Address wrap from the top of the address space
        issue(1'b1, 1'b0, 32'd0, 32'h00001111);
        issue(1'b0, 1'b1, 32'hFFFFFFFF, 32'h0);
        chk("wrap_rdata", resp_rdata, 32'h00001111);
        issue(1'b1, 1'b1, 32'hFFFFFFFF, 32'h77776666);
        chk("wrap_store_mem0", {16'h0, mem[0]}, 32'h6666);

        // Reset while the second word of a double store is pending
        req_valid = 1'b1; req_write = 1'b1; req_double = 1'b1;
        req_addr = 32'd20; req_wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        ref_mem[20] = 16'hAAAA;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
        chk("midrst_valid", resp_valid, 1'b0);
        chk("midrst_rdata", resp_rdata, 32'h0);
        chk("midrst_err", resp_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle_cycle();
        chk("midrst_rdata_after", resp_rdata, 32'h0);
        chk("midrst_mem21", {16'h0, mem[21]}, {16'h0, ref_mem[21]});
        chk("midrst_mem20", {16'h0, mem[20]}, 32'hAAAA);

        // Randomized traffic against the reference memory
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            if ($urandom_range(4) == 0) begin
                idle_cycle();
            end else begin
                if ($urandom_range(7) == 0) a = 32'hFFFFFFFF - 32'($urandom_range(1));
                else                        a = 32'($urandom_range(35));
                issue(1'($urandom), 1'($urandom), a, $urandom);
            end
        end

        mism = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (mem[k] !== ref_mem[k]) mism++;
        end
        chk("final_mem_mismatches", 32'(mism), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_access_unit
`default_nettype wire
